// File: rtl/psum_gather_if.sv
`default_nettype none
// ============================================================================
//  Module      : psum_gather_if
//  Description : Handshake bundle between the serial partial-sum stream,
//                psum_gather, and the downstream reduction stage.
//                  in_valid / in_ready / in_data / in_last : element stream
//                  out_valid / out_ready / out_data / out_count : lane vector
//                slave  modport : the gather block (sinks the stream,
//                                 sources the vector)
//                master modport : the environment around it
//  Revision    : 1.0  initial release
// ============================================================================
interface psum_gather_if #(
    parameter int BETA          = 4,
    parameter int ADD_DATAWIDTH = 32
);
    localparam int c_cnt_w = ($clog2(BETA + 1) < 1) ? 1 : $clog2(BETA + 1);

    logic                               in_valid;
    logic                               in_ready;
    logic [ADD_DATAWIDTH-1:0]           in_data;
    logic                               in_last;
    logic                               out_valid;
    logic                               out_ready;
    logic [BETA-1:0][ADD_DATAWIDTH-1:0] out_data;
    logic [c_cnt_w-1:0]                 out_count;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );
endinterface
`default_nettype wire

// File: rtl/psum_gather.sv
`default_nettype none
// ============================================================================
//  Module      : psum_gather
//  Description : Packs a serial stream of fp32 partial sums into a BETA-lane
//                vector for the final-sum adder tree. A group closes when
//                lane BETA-1 is filled or an element carries in_last; unused
//                lanes are zero. One fill buffer plus one output register
//                sustain one element per cycle while the consumer accepts.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - psum_gather_if.slave (input stream / output vector)
//  Revision    : 1.0  initial release
// ============================================================================
module psum_gather #(
    parameter int BETA          = 4,
    parameter int ADD_DATAWIDTH = 32
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    psum_gather_if.slave  bus
);
    localparam int                 c_cnt_w     = ($clog2(BETA + 1) < 1) ? 1 : $clog2(BETA + 1);
    localparam logic [c_cnt_w-1:0] c_last_lane = c_cnt_w'(BETA - 1);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                              r_state;
    state_t                              w_state_nxt;

    logic [BETA-1:0][ADD_DATAWIDTH-1:0]  r_fill_buf;
    logic [c_cnt_w-1:0]                  r_fill_cnt;
    logic                                r_out_valid;
    logic [BETA-1:0][ADD_DATAWIDTH-1:0]  r_out_data;
    logic [c_cnt_w-1:0]                  r_out_count;

    logic                                w_in_ready;
    logic                                w_in_fire;
    logic                                w_done;
    logic                                w_slot_free;
    logic                                w_load;
    logic [c_cnt_w-1:0]                  w_cnt;
    logic [BETA-1:0][ADD_DATAWIDTH-1:0]  w_vec;
    logic [BETA-1:0][ADD_DATAWIDTH-1:0]  w_vec_masked;

    // in_ready is a pure function of state so it never depends on in_valid.
    assign w_in_ready  = (r_state == ST_FILL);
    assign w_in_fire   = bus.in_valid && w_in_ready;
    assign w_done      = w_in_fire && (bus.in_last || (r_fill_cnt == c_last_lane));
    assign w_slot_free = !r_out_valid || bus.out_ready;

    // Populated-lane count including the element accepted this cycle. In
    // HOLD nothing is accepted, so this is simply the retained count.
    assign w_cnt = r_fill_cnt + c_cnt_w'(w_in_fire);

    // Assembled vector: the buffer with this cycle's element merged into its
    // lane, then every lane at or above the count forced to zero.
    for (genvar l = 0; l < BETA; l++) begin : g_lane
        localparam logic [c_cnt_w-1:0] c_lane = c_cnt_w'(l);
        assign w_vec[l]        = (w_in_fire && (r_fill_cnt == c_lane)) ? bus.in_data : r_fill_buf[l];
        assign w_vec_masked[l] = (c_lane < w_cnt) ? w_vec[l] : '0;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_done) begin
                    if (w_slot_free) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_buf  <= '0;
            r_fill_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else begin
            // Output slot: a load replaces the current group even when it is
            // being accepted this same edge, so out_valid stays high.
            if (w_load) begin
                r_out_data  <= w_vec_masked;
                r_out_count <= w_cnt;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            // Fill buffer: cleared when its group moves out; otherwise it
            // absorbs the accepted element (also when entering HOLD, where
            // the count may legitimately reach BETA).
            if (w_load) begin
                r_fill_buf <= '0;
                r_fill_cnt <= '0;
            end else if (w_in_fire) begin
                r_fill_buf <= w_vec;
                r_fill_cnt <= w_cnt;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_psum_gather.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_gather
//  Description : Self-checking bench for psum_gather. Two instances (BETA=4
//                and BETA=1) receive the same stimulus; a group-level
//                scoreboard predicts every emitted vector and the handshake
//                levels from the number of completed-but-unconsumed groups.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_psum_gather;

    typedef struct packed {
        logic [127:0] d;
        logic [2:0]   c;
    } grp_t;

    logic clk;
    logic rst_n;

    psum_gather_if #(.BETA(4), .ADD_DATAWIDTH(32)) bus4 ();
    psum_gather_if #(.BETA(1), .ADD_DATAWIDTH(32)) bus1 ();

    psum_gather #(.BETA(4), .ADD_DATAWIDTH(32)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    psum_gather #(.BETA(1), .ADD_DATAWIDTH(32)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // current stimulus
    logic        s_iv;
    logic [31:0] s_id;
    logic        s_il;
    logic        s_or;

    // reference model state, index 0 -> BETA=4, index 1 -> BETA=1
    grp_t         q0[$];
    grp_t         q1[$];
    logic [127:0] cur_d  [2];
    int           cur_n  [2];
    logic         prev_ov[2];
    logic         prev_or[2];
    logic [127:0] prev_od[2];
    logic [2:0]   prev_oc[2];

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic string tg(input int k, input string s);
        return $sformatf("beta%0d_%s", (k == 0) ? 4 : 1, s);
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            cur_d[k]   = '0;
            cur_n[k]   = 0;
            prev_ov[k] = 1'b0;
            prev_or[k] = 1'b0;
            prev_od[k] = '0;
            prev_oc[k] = '0;
        end
    endtask

    // One cycle of the reference model, evaluated on values stable before
    // the next rising edge. "outst" = groups completed but not yet consumed.
    task automatic model_step(input int k, input int beta, input logic ir, input logic ov,
                              input logic [127:0] od, input logic [2:0] oc);
        int   outst;
        grp_t g;
        outst = (k == 0) ? q0.size() : q1.size();

        check_value(tg(k, "in_ready"),  128'(ir), 128'(outst < 2));
        check_value(tg(k, "out_valid"), 128'(ov), 128'(outst > 0));

        if (prev_ov[k] && !prev_or[k]) begin
            check_value(tg(k, "stable_data"),  od,       prev_od[k]);
            check_value(tg(k, "stable_count"), 128'(oc), 128'(prev_oc[k]));
        end

        if (ov && s_or && outst > 0) begin
            g = (k == 0) ? q0.pop_front() : q1.pop_front();
            check_value(tg(k, "out_data"),  od,       g.d);
            check_value(tg(k, "out_count"), 128'(oc), 128'(g.c));
        end

        if (s_iv && outst < 2) begin
            cur_d[k][32*cur_n[k] +: 32] = s_id;
            cur_n[k]++;
            if (s_il || cur_n[k] == beta) begin
                g.d = cur_d[k];
                g.c = 3'(cur_n[k]);
                if (k == 0) q0.push_back(g);
                else        q1.push_back(g);
                cur_d[k] = '0;
                cur_n[k] = 0;
            end
        end

        prev_ov[k] = ov;
        prev_or[k] = s_or;
        prev_od[k] = od;
        prev_oc[k] = oc;
    endtask

    task automatic drive(input logic iv, input logic [31:0] id, input logic il, input logic orr);
        s_iv = iv; s_id = id; s_il = il; s_or = orr;
        bus4.in_valid = iv; bus4.in_data = id; bus4.in_last = il; bus4.out_ready = orr;
        bus1.in_valid = iv; bus1.in_data = id; bus1.in_last = il; bus1.out_ready = orr;
    endtask

    task automatic cycle(input logic iv, input logic [31:0] id, input logic il, input logic orr);
        @(posedge clk);
        #1;
        drive(iv, id, il, orr);
        @(negedge clk);
        model_step(0, 4, bus4.in_ready, bus4.out_valid, 128'(bus4.out_data), 3'(bus4.out_count));
        model_step(1, 1, bus1.in_ready, bus1.out_valid, 128'(bus1.out_data), 3'(bus1.out_count));
    endtask

    task automatic check_reset_outputs(input string when_s);
        check_value({when_s, "_b4_out_valid"}, 128'(bus4.out_valid), 128'd0);
        check_value({when_s, "_b4_out_data"},  128'(bus4.out_data),  128'd0);
        check_value({when_s, "_b4_out_count"}, 128'(bus4.out_count), 128'd0);
        check_value({when_s, "_b1_out_valid"}, 128'(bus1.out_valid), 128'd0);
        check_value({when_s, "_b1_out_data"},  128'(bus1.out_data),  128'd0);
        check_value({when_s, "_b1_out_count"}, 128'(bus1.out_count), 128'd0);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] fp_seq [4];
        int          phase;
        logic        orr;

        fp_seq[0] = 32'h3F80_0000;
        fp_seq[1] = 32'h4000_0000;
        fp_seq[2] = 32'h4040_0000;
        fp_seq[3] = 32'h4080_0000;

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0 .. 4.0 back to back with the consumer always ready
        for (int i = 0; i < 4; i++) cycle(1'b1, fp_seq[i], 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // short group closed by in_last, then a fresh group
        cycle(1'b1, 32'hAAAA_0001, 1'b0, 1'b1);
        cycle(1'b1, 32'hBBBB_0002, 1'b1, 1'b1);
        cycle(1'b1, 32'hCCCC_0003, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // backpressure: eight elements with the consumer stalled
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // continuous 12-element stream
        for (int i = 0; i < 12; i++) cycle(1'b1, 32'h2000_0000 + 32'(i), 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // X, Y with out_ready toggling
        cycle(1'b1, 32'h5555_0001, 1'b0, 1'b1);
        cycle(1'b1, 32'h5555_0002, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // reset with two lanes loaded and a group pending at the output
        cycle(1'b1, 32'h6666_0001, 1'b1, 1'b0);
        cycle(1'b1, 32'h6666_0002, 1'b0, 1'b0);
        cycle(1'b1, 32'h6666_0003, 1'b0, 1'b0);
        mid_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h7777_0000 + 32'(i), 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // randomized traffic in phases of varying backpressure
        for (int i = 0; i < 900; i++) begin
            phase = (i / 40) % 3;
            case (phase)
                0:       orr = 1'b1;
                1:       orr = 1'($urandom_range(0, 1));
                default: orr = ($urandom_range(0, 4) == 0);
            endcase
            cycle(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) == 0), orr);
            if (i == 450) mid_reset();
        end

        // drain everything that was completed
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check_value("beta4_drained", 128'(q0.size()), 128'd0);
        check_value("beta1_drained", 128'(q1.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
